// File: rtl/instr_fetch.sv
// Instruction-fetch front end: drives the PC to a combinational instruction memory,
// buffers {pc, instr} in a 2-entry FIFO and hands entries to decode via valid/ready.
module instr_fetch #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RESET_PC = 100,
    parameter int PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        count_q, count_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;

    logic [ADDR_W-1:0] pc_buf_q    [2];
    logic [DATA_W-1:0] instr_buf_q [2];

    logic pop;
    logic push;
    logic unused_redirect_lo;

    // Redirect targets are forced word-aligned, so the low bits are ignored.
    assign unused_redirect_lo = ^redirect_pc[1:0];

    assign out_valid = (count_q != 2'd0);
    assign out_pc    = out_valid ? pc_buf_q[rd_ptr_q]    : '0;
    assign out_instr = out_valid ? instr_buf_q[rd_ptr_q] : '0;
    assign imem_addr = pc_q;

    assign pop  = out_valid & out_ready;
    assign push = fetch_en & ~redirect_valid & ((count_q < 2'd2) | pop);

    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect_valid) begin
            // Flush wins over everything: a same-cycle pop is discarded, not consumed.
            pc_d     = {redirect_pc[ADDR_W-1:2], 2'b00};
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (push) begin
                pc_d     = pc_q + ADDR_W'(PC_STEP);
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            if (push && !pop) begin
                count_d = count_q + 2'd1;
            end else if (pop && !push) begin
                count_d = count_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= ADDR_W'(RESET_PC);
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Entry storage carries no reset; outputs are masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_buf_q[wr_ptr_q]    <= pc_q;
            instr_buf_q[wr_ptr_q] <= imem_data;
        end
    end

endmodule
